// File: rtl/uart_rx_fifo_if.sv
// Host-side bundle of the UART receiver: FIFO drain strobe, head word, status and error pulses.
// The receiver uses the slave modport and the host logic uses the master modport.
interface uart_rx_fifo_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4
) ();
    logic                              rd_en;
    logic [DATA_BITS-1:0]              rx_data;
    logic                              rx_valid;
    logic                              fifo_full;
    logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count;
    logic                              frame_err;
    logic                              parity_err;
    logic                              overrun_err;
    logic                              busy;

    modport master (
        output rd_en,
        input  rx_data, rx_valid, fifo_full, fifo_count,
        input  frame_err, parity_err, overrun_err, busy
    );

    modport slave (
        input  rd_en,
        output rx_data, rx_valid, fifo_full, fifo_count,
        output frame_err, parity_err, overrun_err, busy
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Parametrised oversampling UART receiver with input synchroniser, parity/stop checking
// and a first-word-fall-through receive FIFO with overrun detection.
module uart_rx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 8,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          Sample_clk,
    input  logic          rst_b,
    input  logic          Serial_in,
    uart_rx_fifo_if.slave host
);
    localparam int SCW = $clog2(OVERSAMPLE);
    localparam int BCW = 4;
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = $clog2(FIFO_DEPTH + 1);

    localparam logic [SCW-1:0] SC_HALF = SCW'(OVERSAMPLE / 2 - 1);
    localparam logic [SCW-1:0] SC_FULL = SCW'(OVERSAMPLE - 1);
    localparam logic [BCW-1:0] BC_DATA = BCW'(DATA_BITS - 1);
    localparam logic [BCW-1:0] BC_STOP = BCW'(STOP_BITS - 1);
    localparam logic           PAR_EN  = (PARITY_EN != 0);
    localparam logic           PAR_ODD = (PARITY_ODD != 0);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;

    state_t                 state, state_nxt;
    logic                   sync1, ser_s;
    logic [SCW-1:0]         sc, sc_nxt;
    logic [BCW-1:0]         bc, bc_nxt;
    logic [DATA_BITS-1:0]   shreg, shreg_nxt;
    logic                   par_bad, par_bad_nxt;
    logic                   stop_bad, stop_bad_nxt;
    logic                   push_c, frame_c, parity_c;
    logic                   push_p, frame_p, parity_p;
    logic [DATA_BITS-1:0]   word_p;

    logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
    logic [PW-1:0]          wr_ptr, rd_ptr;
    logic [CW-1:0]          count;
    logic                   full, pop, push_ok;

    always_ff @(posedge Sample_clk or negedge rst_b) begin
        if (!rst_b) begin
            sync1    <= 1'b1;
            ser_s    <= 1'b1;
            state    <= IDLE;
            sc       <= '0;
            bc       <= '0;
            shreg    <= '0;
            par_bad  <= 1'b0;
            stop_bad <= 1'b0;
            push_p   <= 1'b0;
            frame_p  <= 1'b0;
            parity_p <= 1'b0;
            word_p   <= '0;
        end else begin
            sync1    <= Serial_in;
            ser_s    <= sync1;
            state    <= state_nxt;
            sc       <= sc_nxt;
            bc       <= bc_nxt;
            shreg    <= shreg_nxt;
            par_bad  <= par_bad_nxt;
            stop_bad <= stop_bad_nxt;
            push_p   <= push_c;
            frame_p  <= frame_c;
            parity_p <= parity_c;
            word_p   <= shreg;
        end
    end

    // Frame decisions are made on the final stop sample; stop errors take priority over parity.
    always_comb begin
        state_nxt    = state;
        sc_nxt       = sc;
        bc_nxt       = bc;
        shreg_nxt    = shreg;
        par_bad_nxt  = par_bad;
        stop_bad_nxt = stop_bad;
        push_c       = 1'b0;
        frame_c      = 1'b0;
        parity_c     = 1'b0;
        case (state)
            IDLE: begin
                if (!ser_s) begin
                    state_nxt = START;
                    sc_nxt    = '0;
                end
            end
            START: begin
                if (sc == SC_HALF) begin
                    if (ser_s) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt    = DATA;
                        sc_nxt       = '0;
                        bc_nxt       = '0;
                        par_bad_nxt  = 1'b0;
                        stop_bad_nxt = 1'b0;
                    end
                end else begin
                    sc_nxt = sc + SCW'(1);
                end
            end
            DATA: begin
                if (sc == SC_FULL) begin
                    shreg_nxt = {ser_s, shreg[DATA_BITS-1:1]};
                    sc_nxt    = '0;
                    bc_nxt    = bc + BCW'(1);
                    if (bc == BC_DATA) begin
                        bc_nxt    = '0;
                        state_nxt = PAR_EN ? PARITY : STOP;
                    end
                end else begin
                    sc_nxt = sc + SCW'(1);
                end
            end
            PARITY: begin
                if (sc == SC_FULL) begin
                    par_bad_nxt = ser_s ^ (^shreg) ^ PAR_ODD;
                    sc_nxt      = '0;
                    state_nxt   = STOP;
                end else begin
                    sc_nxt = sc + SCW'(1);
                end
            end
            STOP: begin
                if (sc == SC_FULL) begin
                    sc_nxt = '0;
                    bc_nxt = bc + BCW'(1);
                    if (!ser_s) stop_bad_nxt = 1'b1;
                    if (bc == BC_STOP) begin
                        if (stop_bad || !ser_s) begin
                            frame_c   = 1'b1;
                            state_nxt = WAIT_HIGH;
                        end else if (par_bad) begin
                            parity_c  = 1'b1;
                            state_nxt = IDLE;
                        end else begin
                            push_c    = 1'b1;
                            state_nxt = IDLE;
                        end
                    end
                end else begin
                    sc_nxt = sc + SCW'(1);
                end
            end
            WAIT_HIGH: begin
                if (ser_s) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A push into a full FIFO still succeeds when the host pops in the same cycle.
    assign full    = (count == CW'(FIFO_DEPTH));
    assign pop     = host.rd_en && (count != '0);
    assign push_ok = push_p && (!full || pop);

    always_ff @(posedge Sample_clk or negedge rst_b) begin
        if (!rst_b) begin
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            count            <= '0;
            host.frame_err   <= 1'b0;
            host.parity_err  <= 1'b0;
            host.overrun_err <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop)     rd_ptr <= rd_ptr + PW'(1);
            if (push_ok && !pop)      count <= count + CW'(1);
            else if (pop && !push_ok) count <= count - CW'(1);
            host.frame_err   <= frame_p;
            host.parity_err  <= parity_p;
            host.overrun_err <= push_p && full && !pop;
        end
    end

    always_ff @(posedge Sample_clk) begin
        if (push_ok) mem[wr_ptr] <= word_p;
    end

    assign host.rx_valid   = (count != '0);
    assign host.fifo_full  = full;
    assign host.fifo_count = count;
    assign host.rx_data    = host.rx_valid ? mem[rd_ptr] : '0;
    assign host.busy       = (state != IDLE);
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: stimulus pushes expected words and error pulses into queues,
// a monitor pops them when the host pops a word or an error pulse appears.
module tb_uart_rx_fifo;
    localparam int DATA_BITS  = 8;
    localparam int OS         = 8;
    localparam int FIFO_DEPTH = 4;

    logic Sample_clk = 1'b0;
    logic rst_b      = 1'b0;
    logic Serial_in  = 1'b1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int fall_cyc = 0;
    int valid_rise_cyc = -1;
    int err_cyc = -1;
    logic prev_valid = 1'b0;

    logic [7:0] exp_data[$];
    logic [2:0] exp_evt[$];

    uart_rx_fifo_if #(.DATA_BITS(DATA_BITS), .FIFO_DEPTH(FIFO_DEPTH)) host ();

    uart_rx_fifo #(
        .DATA_BITS(DATA_BITS), .OVERSAMPLE(OS), .PARITY_EN(1), .PARITY_ODD(0),
        .STOP_BITS(1), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .Sample_clk(Sample_clk),
        .rst_b(rst_b),
        .Serial_in(Serial_in),
        .host(host)
    );

    always #5 Sample_clk = ~Sample_clk;

    always @(posedge Sample_clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Frame layout: start, 8 data bits LSB first, even parity (optionally corrupted), one stop bit.
    task automatic applyStimulus(input logic [7:0] data, input logic flip_par, input logic stop_bit);
        logic [10:0] bits;
        bits = {stop_bit, (^data) ^ flip_par, data, 1'b0};
        @(negedge Sample_clk);
        fall_cyc = cyc;
        for (int i = 0; i < 11; i++) begin
            Serial_in = bits[i];
            repeat (OS) @(negedge Sample_clk);
        end
    endtask

    task automatic popWord();
        @(negedge Sample_clk);
        host.rd_en = 1'b1;
        @(negedge Sample_clk);
        host.rd_en = 1'b0;
    endtask

    // Monitor: pops expected words on host pops and expected codes {frame,parity,overrun} on pulses.
    always @(negedge Sample_clk) begin
        logic [2:0] evt;
        #1;
        if (host.rx_valid && !prev_valid) valid_rise_cyc = cyc;
        prev_valid = host.rx_valid;
        if (host.rd_en && host.rx_valid) begin
            if (exp_data.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_pop: got 0x%0h expected no word", host.rx_data);
            end else begin
                checkOutput("pop_data", 32'(host.rx_data), 32'(exp_data.pop_front()));
            end
        end
        evt = {host.frame_err, host.parity_err, host.overrun_err};
        if (evt != 3'b000) begin
            err_cyc = cyc;
            if (exp_evt.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_pulse: got %b expected none", evt);
            end else begin
                checkOutput("err_pulse", 32'(evt), 32'(exp_evt.pop_front()));
            end
        end
    end

    initial begin
        host.rd_en = 1'b0;
        #1;
        checkOutput("reset_rx_valid", 32'(host.rx_valid), 0);
        checkOutput("reset_fifo_count", 32'(host.fifo_count), 0);
        checkOutput("reset_busy", 32'(host.busy), 0);
        checkOutput("reset_rx_data", 32'(host.rx_data), 0);
        checkOutput("reset_errs", 32'({host.frame_err, host.parity_err, host.overrun_err, host.fifo_full}), 0);
        repeat (3) @(negedge Sample_clk);
        rst_b = 1'b1;
        repeat (4) @(negedge Sample_clk);

        // Cycle 0 is the first Sample_clk edge after the falling edge of the start bit.
        $display("[TB] good frame 0x5A");
        exp_data.push_back(8'h5A);
        applyStimulus(8'h5A, 1'b0, 1'b1);
        @(negedge Sample_clk);
        checkOutput("valid_latency", 32'(valid_rise_cyc - fall_cyc - 1), 87);
        checkOutput("count_one", 32'(host.fifo_count), 1);
        checkOutput("head_5a", 32'(host.rx_data), 32'h5A);
        popWord();
        checkOutput("count_after_pop", 32'(host.fifo_count), 0);

        $display("[TB] parity error frame");
        exp_evt.push_back(3'b010);
        applyStimulus(8'h5A, 1'b1, 1'b1);
        @(negedge Sample_clk);
        checkOutput("parity_latency", 32'(err_cyc - fall_cyc - 1), 87);
        checkOutput("parity_no_valid", 32'(host.rx_valid), 0);

        $display("[TB] framing error with stuck-low line");
        exp_evt.push_back(3'b100);
        applyStimulus(8'h3C, 1'b0, 1'b0);
        repeat (31) @(negedge Sample_clk);
        checkOutput("busy_while_low", 32'(host.busy), 1);
        @(negedge Sample_clk);
        Serial_in = 1'b1;
        repeat (2) @(negedge Sample_clk);
        checkOutput("busy_release_plus1", 32'(host.busy), 1);
        @(negedge Sample_clk);
        checkOutput("busy_release_plus2", 32'(host.busy), 0);
        repeat (30) @(negedge Sample_clk);
        checkOutput("no_spurious_start", 32'({host.busy, host.fifo_count}), 0);

        $display("[TB] start glitch");
        @(negedge Sample_clk);
        Serial_in = 1'b0;
        repeat (3) @(negedge Sample_clk);
        Serial_in = 1'b1;
        repeat (2) @(negedge Sample_clk);
        checkOutput("glitch_busy", 32'(host.busy), 1);
        repeat (10) @(negedge Sample_clk);
        checkOutput("glitch_idle", 32'({host.busy, host.fifo_count}), 0);

        $display("[TB] overrun on fifth frame");
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) exp_data.push_back(8'(i));
            else        exp_evt.push_back(3'b001);
            applyStimulus(8'(i), 1'b0, 1'b1);
            checkOutput($sformatf("full_after_%0d", i), 32'(host.fifo_full), (i >= 4) ? 1 : 0);
        end
        checkOutput("count_after_overrun", 32'(host.fifo_count), 4);
        repeat (4) popWord();
        checkOutput("count_drained", 32'(host.fifo_count), 0);

        $display("[TB] push and pop together while full");
        for (int i = 1; i <= 4; i++) begin
            exp_data.push_back(8'(i));
            applyStimulus(8'(i), 1'b0, 1'b1);
        end
        checkOutput("full_before_pop", 32'(host.fifo_full), 1);
        exp_data.push_back(8'h05);
        fork
            applyStimulus(8'h05, 1'b0, 1'b1);
            begin
                repeat (88) @(negedge Sample_clk);
                host.rd_en = 1'b1;
                @(negedge Sample_clk);
                host.rd_en = 1'b0;
            end
        join
        checkOutput("count_stays_4", 32'(host.fifo_count), 4);
        checkOutput("still_full", 32'(host.fifo_full), 1);
        repeat (4) popWord();

        $display("[TB] reset mid-frame");
        exp_data.push_back(8'h77);
        applyStimulus(8'h77, 1'b0, 1'b1);
        @(negedge Sample_clk);
        Serial_in = 1'b0;
        repeat (8) @(negedge Sample_clk);
        Serial_in = 1'b1;
        repeat (20) @(negedge Sample_clk);
        checkOutput("busy_before_reset", 32'(host.busy), 1);
        #3;
        rst_b = 1'b0;
        exp_data.delete();
        exp_evt.delete();
        #1;
        checkOutput("mid_reset_valid", 32'(host.rx_valid), 0);
        checkOutput("mid_reset_count", 32'(host.fifo_count), 0);
        checkOutput("mid_reset_data", 32'(host.rx_data), 0);
        checkOutput("mid_reset_busy", 32'(host.busy), 0);
        repeat (3) @(negedge Sample_clk);
        rst_b = 1'b1;
        repeat (4) @(negedge Sample_clk);
        exp_data.push_back(8'hC3);
        applyStimulus(8'hC3, 1'b0, 1'b1);
        @(negedge Sample_clk);
        checkOutput("after_reset_count", 32'(host.fifo_count), 1);
        popWord();

        repeat (5) @(negedge Sample_clk);
        checkOutput("data_queue_drained", 32'(exp_data.size()), 0);
        checkOutput("event_queue_drained", 32'(exp_evt.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
